// File: rtl/prescalar_pkg.sv
// Shared definitions for the prescalar_gen clock-enable generator:
// channel state encoding and default build constants.
package prescalar_pkg;

    localparam int PRESC_DIV_W        = 8;
    localparam int PRESC_DEFAULT_DIV  = 1;
    localparam int PRESC_LOCK_PERIODS = 4;
    localparam int PRESC_LOCK_CNT_W   = 8;   // covers LOCK_PERIODS up to 255

    typedef enum logic [1:0] {
        CH_IDLE    = 2'd0,
        CH_LOCKING = 2'd1,
        CH_LOCKED  = 2'd2
    } ch_state_e;

endpackage

// File: rtl/prescalar_chan.sv
// One prescaler channel: free-running divide-by-(D+1) counter producing a
// 0-degree enable at cnt==D and (with PRESCALAR_GEN_PHASE180_EN defined) a
// 180-degree enable at cnt==D>>1, plus a lock detector and a one-deep
// pending-divisor slot applied on period boundaries.
module prescalar_chan
    import prescalar_pkg::*;
#(
    parameter int DIV_W        = PRESC_DIV_W,
    parameter int DEFAULT_DIV  = PRESC_DEFAULT_DIV,
    parameter int LOCK_PERIODS = PRESC_LOCK_PERIODS
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             run,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             en,
    output logic             en180,
    output logic             locked,
    output logic             pend
);

    localparam logic [PRESC_LOCK_CNT_W-1:0] LOCK_LAST = PRESC_LOCK_CNT_W'(LOCK_PERIODS - 1);
    localparam logic [DIV_W-1:0]            DIV_RST   = DIV_W'(DEFAULT_DIV);

    ch_state_e                    state;
    logic [DIV_W-1:0]             cnt;
    logic [DIV_W-1:0]             div;
    logic [DIV_W-1:0]             pend_div;
    logic [PRESC_LOCK_CNT_W-1:0]  lock_cnt;

    logic                         term;
    logic                         apply;
    logic                         chg;
    logic [DIV_W-1:0]             cnt_nx;
    logic [DIV_W-1:0]             div_nx;

    // Next counter/divisor values; the enables are registered against these
    // so en/en180 line up with the cycle in which cnt holds the match value.
    always_comb begin
        term   = (cnt == div);
        apply  = run && pend && ((state == CH_IDLE) || term);
        chg    = (pend_div != div);
        cnt_nx = cnt + 1'b1;
        if (!run || (state == CH_IDLE) || term)
            cnt_nx = '0;
        div_nx = apply ? pend_div : div;
    end

    // Channel FSM, counter, pending slot and registered outputs.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state    <= CH_IDLE;
            cnt      <= '0;
            div      <= DIV_RST;
            pend_div <= '0;
            pend     <= 1'b0;
            lock_cnt <= '0;
            en       <= 1'b0;
            locked   <= 1'b0;
        end else begin
            cnt <= cnt_nx;
            div <= div_nx;
            en  <= run && (cnt_nx == div_nx);

            // Apply and a new write never coincide: writes need pend low.
            if (apply)
                pend <= 1'b0;
            if (wr) begin
                pend     <= 1'b1;
                pend_div <= wr_div;
            end

            if (!run) begin
                state    <= CH_IDLE;
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                case (state)
                    CH_IDLE: begin
                        state    <= CH_LOCKING;
                        lock_cnt <= '0;
                        locked   <= 1'b0;
                    end
                    CH_LOCKING: begin
                        if (term) begin
                            if (apply && chg) begin
                                lock_cnt <= '0;
                            end else if (lock_cnt == LOCK_LAST) begin
                                state    <= CH_LOCKED;
                                locked   <= 1'b1;
                                lock_cnt <= '0;
                            end else begin
                                lock_cnt <= lock_cnt + 1'b1;
                            end
                        end
                    end
                    CH_LOCKED: begin
                        if (apply && chg) begin
                            state    <= CH_LOCKING;
                            locked   <= 1'b0;
                            lock_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= CH_IDLE;
                        lock_cnt <= '0;
                        locked   <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PRESCALAR_GEN_PHASE180_EN
    // Half-period enable, registered like en.
    always_ff @(posedge clkin) begin
        if (!rst_n)
            en180 <= 1'b0;
        else
            en180 <= run && (cnt_nx == (div_nx >> 1));
    end
`else
    assign en180 = 1'b0;
`endif

endmodule

// File: rtl/prescalar_gen.sv
// Multi-channel clock-enable prescaler. Top level decodes the divisor-update
// handshake and fans it out to NUM_CH independent prescalar_chan instances.
// Optional feature macro: PRESCALAR_GEN_PHASE180_EN (enables en180_o).
module prescalar_gen
    import prescalar_pkg::*;
#(
    parameter int  NUM_CH       = 3,
    parameter int  DIV_W        = PRESC_DIV_W,
    parameter int  DEFAULT_DIV  = PRESC_DEFAULT_DIV,
    parameter int  LOCK_PERIODS = PRESC_LOCK_PERIODS,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    output logic [NUM_CH-1:0] en_o,
    output logic [NUM_CH-1:0] en180_o,
    output logic [NUM_CH-1:0] locked_o
);

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] wr;

    // Ready reflects the addressed channel's pending slot; an address past
    // the last channel stays ready and the write is silently dropped.
    always_comb begin
        cfg_ready_o = 1'b1;
        wr          = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch_i == CH_W'(i)) begin
                cfg_ready_o = !pend[i];
                wr[i]       = cfg_valid_i && !pend[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        prescalar_chan #(
            .DIV_W        (DIV_W),
            .DEFAULT_DIV  (DEFAULT_DIV),
            .LOCK_PERIODS (LOCK_PERIODS)
        ) u_chan (
            .clkin  (clkin),
            .rst_n  (rst_n),
            .run    (ch_en_i[g]),
            .wr     (wr[g]),
            .wr_div (cfg_div_i),
            .en     (en_o[g]),
            .en180  (en180_o[g]),
            .locked (locked_o[g]),
            .pend   (pend[g])
        );
    end

endmodule
